// File: rtl/counter_100.sv
// counter_100: four-digit BCD elapsed-time counter (SS.hh) for the
// seven-segment display path. Clocked by the 1 kHz CE strobe; an internal
// divide-by-PRESCALE prescaler produces the 100 Hz count tick.
module counter_100 #(
  parameter int PRESCALE = 10
) (
  input  logic       CE,
  input  logic       RESET,
  output logic [3:0] CNT1,
  output logic [3:0] CNT2,
  output logic [3:0] CNT3,
  output logic [3:0] CNT4
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          carry1;
  logic          carry2;
  logic          carry3;

  // Tick on the edge where the prescaler sits at its last phase.
  assign tick   = (presc == PRESC_LAST);
  assign carry1 = tick   && (CNT1 == 4'd9);
  assign carry2 = carry1 && (CNT2 == 4'd9);
  assign carry3 = carry2 && (CNT3 == 4'd9);

  // Prescaler: counts CE edges 0..PRESCALE-1 and restarts on the tick edge.
  always_ff @(posedge CE or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Hundredths digit: advances on every tick, wraps 9 -> 0.
  always_ff @(posedge CE or posedge RESET) begin
    if (RESET) begin
      CNT1 <= 4'd0;
    end else if (tick) begin
      CNT1 <= (CNT1 == 4'd9) ? 4'd0 : CNT1 + 4'd1;
    end
  end

  // Tenths digit: advances only on a hundredths carry.
  always_ff @(posedge CE or posedge RESET) begin
    if (RESET) begin
      CNT2 <= 4'd0;
    end else if (carry1) begin
      CNT2 <= (CNT2 == 4'd9) ? 4'd0 : CNT2 + 4'd1;
    end
  end

  // Units-of-seconds digit: advances only on a tenths carry.
  always_ff @(posedge CE or posedge RESET) begin
    if (RESET) begin
      CNT3 <= 4'd0;
    end else if (carry2) begin
      CNT3 <= (CNT3 == 4'd9) ? 4'd0 : CNT3 + 4'd1;
    end
  end

  // Tens-of-seconds digit: advances on a units carry; 9 wraps to 0 with no
  // further carry, so 99.99 rolls straight to 00.00.
  always_ff @(posedge CE or posedge RESET) begin
    if (RESET) begin
      CNT4 <= 4'd0;
    end else if (carry3) begin
      CNT4 <= (CNT4 == 4'd9) ? 4'd0 : CNT4 + 4'd1;
    end
  end

endmodule

// File: tb/tb_counter_100.sv
// tb_counter_100: directed checks of counter_100 at PRESCALE 10 (nominal),
// 1 (full 99.99 wrap in a short run) and 16 (top of the legal range).
module tb_counter_100;

  logic ce_a = 1'b0;
  logic ce_b = 1'b0;
  logic ce_c = 1'b0;
  logic rst  = 1'b0;
  logic [3:0] a1, a2, a3, a4;
  logic [3:0] b1, b2, b3, b4;
  logic [3:0] c1, c2, c3, c4;

  int checks = 0;
  int errors = 0;
  int edges_a = 0;
  int edges_b = 0;
  int edges_c = 0;

  counter_100 #(.PRESCALE(10)) dut_a (
    .CE(ce_a), .RESET(rst), .CNT1(a1), .CNT2(a2), .CNT3(a3), .CNT4(a4)
  );
  counter_100 #(.PRESCALE(1)) dut_b (
    .CE(ce_b), .RESET(rst), .CNT1(b1), .CNT2(b2), .CNT3(b3), .CNT4(b4)
  );
  counter_100 #(.PRESCALE(16)) dut_c (
    .CE(ce_c), .RESET(rst), .CNT1(c1), .CNT2(c2), .CNT3(c3), .CNT4(c4)
  );

  typedef struct {
    string       name;
    int          edges;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] bcd(input int n);
    int m;
    m = n % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic legal(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CE period per call; every edge is compared against edges/PRESCALE.
  task automatic pulse_a();
    ce_a = 1'b1; #5; ce_a = 1'b0; #5;
    edges_a++;
    check("track_p10", {a4, a3, a2, a1}, bcd(edges_a / 10));
  endtask

  task automatic pulse_b();
    ce_b = 1'b1; #5; ce_b = 1'b0; #5;
    edges_b++;
    check("track_p1", {b4, b3, b2, b1}, bcd(edges_b));
    check("bcd_legal_p1", {15'd0, legal({b4, b3, b2, b1})}, 16'd1);
  endtask

  task automatic pulse_c();
    ce_c = 1'b1; #5; ce_c = 1'b0; #5;
    edges_c++;
    check("track_p16", {c4, c3, c2, c1}, bcd(edges_c / 16));
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] now;

    vecs[0] = '{"p10_9_edges",     9,     16'h0000};
    vecs[1] = '{"p10_10_edges",    10,    16'h0001};
    vecs[2] = '{"p10_90_edges",    90,    16'h0009};
    vecs[3] = '{"p10_99_edges",    99,    16'h0009};
    vecs[4] = '{"p10_100_edges",   100,   16'h0010};
    vecs[5] = '{"p10_1000_edges",  1000,  16'h0100};
    vecs[6] = '{"p10_12340_edges", 12340, 16'h1234};

    // Power-up reset with CE idle.
    #5;
    rst = 1'b1;
    #100;
    check("reset_p10", {a4, a3, a2, a1}, 16'h0000);
    check("reset_p1",  {b4, b3, b2, b1}, 16'h0000);
    check("reset_p16", {c4, c3, c2, c1}, 16'h0000);
    rst = 1'b0;
    #5;

    // Full cycle at PRESCALE=1: every edge is a tick.
    for (int i = 0; i < 9999; i++) pulse_b();
    check("p1_at_9999", {b4, b3, b2, b1}, 16'h9999);
    prev = {b4, b3, b2, b1};
    pulse_b();
    now = {b4, b3, b2, b1};
    check("p1_wrap_0000", now, 16'h0000);
    check("p1_wrap_all_digits",
          {12'd0, (prev[15:12] != now[15:12]), (prev[11:8] != now[11:8]),
           (prev[7:4] != now[7:4]), (prev[3:0] != now[3:0])}, 16'h000F);
    for (int i = 0; i < 10; i++) pulse_b();

    // Top of the prescale range.
    for (int i = 0; i < 15; i++) pulse_c();
    check("p16_15_edges", {c4, c3, c2, c1}, 16'h0000);
    pulse_c();
    check("p16_16_edges", {c4, c3, c2, c1}, 16'h0001);

    // Nominal prescale: table of cumulative edge counts since reset.
    for (int i = 0; i < 7; i++) begin
      while (edges_a < vecs[i].edges) pulse_a();
      check(vecs[i].name, {a4, a3, a2, a1}, vecs[i].exp);
    end

    // Reset mid-count with a partial prescaler phase, between CE edges.
    for (int i = 0; i < 3; i++) pulse_a();
    rst = 1'b1;
    #1;
    check("mid_reset_immediate", {a4, a3, a2, a1}, 16'h0000);
    #4;
    rst = 1'b0;
    #5;
    edges_a = 0;
    for (int i = 0; i < 9; i++) pulse_a();
    check("after_reset_9_edges", {a4, a3, a2, a1}, 16'h0000);
    pulse_a();
    check("after_reset_10_edges", {a4, a3, a2, a1}, 16'h0001);

    // RESET and a CE rising edge in the same time step: reset wins.
    for (int i = 0; i < 14; i++) pulse_a();
    check("before_simul", {a4, a3, a2, a1}, 16'h0002);
    ce_a = 1'b1;
    rst  = 1'b1;
    #1;
    check("simul_reset_ce", {a4, a3, a2, a1}, 16'h0000);
    #4;
    ce_a = 1'b0;
    rst  = 1'b0;
    #5;
    edges_a = 0;
    for (int i = 0; i < 10; i++) pulse_a();
    check("after_simul_10_edges", {a4, a3, a2, a1}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
